// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants, widths and LFSR helper for the falling-bar game sequencer
package game_pkg;

    // State encoding, visible on the state output
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int ROWS    = 9;    // bar rows, bit0 top .. bit8 bottom
    localparam int LIVES_W = 2;    // width of the lives counter
    localparam int PER_W   = 8;    // width of step period and divider
    localparam int HOLE_W  = 4;    // hole / player column width

    // x^4 + x^3 + 1: feedback is the XOR of bits 3 and 2
    localparam logic [HOLE_W-1:0] LFSR_TAPS = 4'b1100;

    function automatic logic [HOLE_W-1:0] lfsr_next(input logic [HOLE_W-1:0] v);
        return {v[HOLE_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// rtl/game_lfsr.sv - 4-bit Fibonacci LFSR picking hole columns
//   clk   : rising-edge clock
//   load  : synchronous load of SEED (takes priority over adv)
//   adv   : advance one LFSR step
//   value : current LFSR value, never 0 for a nonzero SEED
module game_lfsr
    import game_pkg::*;
#(
    parameter logic [HOLE_W-1:0] SEED = 4'h9
) (
    input  logic              clk,
    input  logic              load,
    input  logic              adv,
    output logic [HOLE_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (load) begin
            value <= SEED;
        end else if (adv) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/game_seq.sv
// rtl/game_seq.sv - round sequencer: game FSM, speed-ramping bar divider, pass/hit scoring
//   gameclk   : sole clock, rising edge
//   clr       : synchronous active-high reset, overrides all inputs
//   start     : one-cycle pulse, starts a game from IDLE or OVER
//   pause     : level, freezes play while high
//   plrpos    : player column 0..15
//   barpos    : one-hot bar row, bit0 top, bit8 bottom
//   holepos   : hole column of the current bar, 1..15
//   lives     : remaining lives
//   timealive : bars passed, saturating
//   state     : IDLE=0, PLAY=1, PAUSE=2, OVER=3
//   bar_step  : one-cycle pulse per bar move
//   hit       : one-cycle pulse per life lost
//   game_over : high while in OVER
module game_seq
    import game_pkg::*;
#(
    parameter int                START_PERIOD = 16,
    parameter int                MIN_PERIOD   = 4,
    parameter int                LIVES_INIT   = 3,
    parameter logic [HOLE_W-1:0] SEED         = 4'h9
) (
    input  logic               gameclk,
    input  logic               clr,
    input  logic               start,
    input  logic               pause,
    input  logic [HOLE_W-1:0]  plrpos,
    output logic [ROWS-1:0]    barpos,
    output logic [HOLE_W-1:0]  holepos,
    output logic [LIVES_W-1:0] lives,
    output logic [15:0]        timealive,
    output logic [1:0]         state,
    output logic               bar_step,
    output logic               hit,
    output logic               game_over
);

    localparam logic [PER_W-1:0]   START_P = PER_W'(START_PERIOD);
    localparam logic [PER_W-1:0]   MIN_P   = PER_W'(MIN_PERIOD);
    localparam logic [PER_W-1:0]   ONE_P   = PER_W'(1);
    localparam logic [LIVES_W-1:0] LIVES_I = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] ONE_L   = LIVES_W'(1);
    localparam logic [ROWS-1:0]    TOP_ROW = ROWS'(1);

    logic [1:0]       next_state;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] div;
    logic [1:0]       pass_cnt;

    logic start_game;
    logic running;
    logic step;
    logic eval;
    logic pass_ok;
    logic miss;
    logic last_life;

    // State register
    always_ff @(posedge gameclk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Decode of the current cycle's events. The divider advances in PAUSE
    // once pause drops, so each PAUSE cycle costs exactly one cycle of delay,
    // and a pause that lands on the wrap cycle defers the step to the resume.
    always_comb begin
        start_game = start && (state == ST_IDLE || state == ST_OVER);
        running    = (state == ST_PLAY || state == ST_PAUSE) && !pause;
        step       = running && (div == period - ONE_P);
        eval       = step && barpos[ROWS-1];
        pass_ok    = eval && (plrpos == holepos);
        miss       = eval && !pass_ok;
        last_life  = (lives == ONE_L);
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_PLAY;
            end
            ST_PLAY: begin
                if (miss && last_life) next_state = ST_OVER;
                else if (pause)        next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (miss && last_life) next_state = ST_OVER;
                else if (!pause)       next_state = ST_PLAY;
            end
            ST_OVER: begin
                if (start) next_state = ST_PLAY;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Divider, bar position and scoring
    always_ff @(posedge gameclk) begin
        if (clr) begin
            barpos    <= TOP_ROW;
            lives     <= LIVES_I;
            timealive <= '0;
            period    <= START_P;
            div       <= '0;
            pass_cnt  <= '0;
            bar_step  <= 1'b0;
            hit       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            bar_step <= step;
            hit      <= miss;
            if (start_game) begin
                barpos    <= TOP_ROW;
                lives     <= LIVES_I;
                timealive <= '0;
                period    <= START_P;
                div       <= '0;
                pass_cnt  <= '0;
                game_over <= 1'b0;
            end else if (running) begin
                if (step) begin
                    div    <= '0;
                    barpos <= barpos[ROWS-1] ? TOP_ROW : (barpos << 1);
                end else begin
                    div <= div + ONE_P;
                end
                if (pass_ok) begin
                    if (timealive != 16'hFFFF) timealive <= timealive + 16'd1;
                    pass_cnt <= pass_cnt + 2'd1;
                    // every 4th pass speeds the game up by one cycle per step
                    if (pass_cnt == 2'd3 && period > MIN_P) period <= period - ONE_P;
                end
                if (miss) begin
                    lives <= lives - ONE_L;
                    if (last_life) game_over <= 1'b1;
                end
            end
        end
    end

    game_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (gameclk),
        .load  (clr),
        .adv   (eval),
        .value (holepos)
    );

endmodule

// File: tb/tb_game_seq.sv
// tb/tb_game_seq.sv - self-checking bench for game_seq
module tb_game_seq;

    logic        gameclk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  plrpos = 4'd0;
    logic [8:0]  barpos;
    logic [3:0]  holepos;
    logic [1:0]  lives;
    logic [15:0] timealive;
    logic [1:0]  state;
    logic        bar_step;
    logic        hit;
    logic        game_over;

    game_seq dut (
        .gameclk   (gameclk),
        .clr       (clr),
        .start     (start),
        .pause     (pause),
        .plrpos    (plrpos),
        .barpos    (barpos),
        .holepos   (holepos),
        .lives     (lives),
        .timealive (timealive),
        .state     (state),
        .bar_step  (bar_step),
        .hit       (hit),
        .game_over (game_over)
    );

    always #5 gameclk = ~gameclk;

    int total = 0;
    int bad   = 0;
    int c     = 0;

    typedef struct {
        bit          do_start;
        logic [3:0]  plr;
        int          cyc;
        logic [8:0]  bar;
        logic [3:0]  hole;
        logic [1:0]  lv;
        logic [15:0] ta;
        logic [1:0]  st;
        logic        bs;
        logic        ht;
        logic        go;
    } vec_t;

    vec_t vecs[15];

    // behavioural reference state
    int         m_state, m_row, m_lives, m_ta, m_passes, m_elapsed;
    logic [3:0] m_hole;
    logic       m_bs, m_hit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] b, input logic [3:0] h,
                           input logic [1:0] l, input logic [15:0] t, input logic [1:0] s,
                           input logic bs, input logic ht, input logic go);
        chk({tag, ".barpos"},    64'(barpos),    64'(b));
        chk({tag, ".holepos"},   64'(holepos),   64'(h));
        chk({tag, ".lives"},     64'(lives),     64'(l));
        chk({tag, ".timealive"}, 64'(timealive), 64'(t));
        chk({tag, ".state"},     64'(state),     64'(s));
        chk({tag, ".bar_step"},  64'(bar_step),  64'(bs));
        chk({tag, ".hit"},       64'(hit),       64'(ht));
        chk({tag, ".game_over"}, 64'(game_over), 64'(go));
    endtask

    task automatic tick();
        @(posedge gameclk);
        #1;
    endtask

    task automatic run_to(input int target);
        while (c < target) begin
            tick();
            c++;
        end
    endtask

    task automatic fresh_game();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
    endtask

    function automatic logic [3:0] nxt_hole(input logic [3:0] h);
        logic [3:0] r;
        r = 4'((h * 2) % 16);
        r[0] = h[3] ^ h[2];
        return r;
    endfunction

    function automatic int cur_period(input int passes);
        int p;
        p = 16 - passes / 4;
        return (p < 4) ? 4 : p;
    endfunction

    task automatic model_edge(input logic c_clr, input logic s, input logic p, input logic [3:0] plr);
        if (c_clr) begin
            m_state = 0; m_row = 0; m_hole = 4'h9; m_lives = 3; m_ta = 0;
            m_passes = 0; m_elapsed = 0; m_bs = 1'b0; m_hit = 1'b0;
        end else begin
            m_bs = 1'b0;
            m_hit = 1'b0;
            if (s && (m_state == 0 || m_state == 3)) begin
                m_state = 1; m_row = 0; m_lives = 3; m_ta = 0; m_passes = 0; m_elapsed = 0;
            end else if (m_state == 1 || m_state == 2) begin
                if (!p) begin
                    m_elapsed++;
                    if (m_elapsed == cur_period(m_passes)) begin
                        m_elapsed = 0;
                        m_bs = 1'b1;
                        if (m_row < 8) begin
                            m_row++;
                        end else begin
                            m_row = 0;
                            if (plr == m_hole) begin
                                if (m_ta < 65535) m_ta++;
                                m_passes++;
                            end else begin
                                m_hit = 1'b1;
                                m_lives--;
                            end
                            m_hole = nxt_hole(m_hole);
                        end
                    end
                end
                if (m_lives == 0) m_state = 3;
                else m_state = p ? 2 : 1;
            end
        end
    endtask

    initial begin
        int passes;
        int last;
        int pause_left;
        logic r_clr, r_start;
        logic [3:0] r_plr;
        logic [63:0] exp_v;

        // checkpoints relative to the start-sampling edge (edge 0)
        vecs[0]  = '{1'b1, 4'd9, 0,    9'h001, 4'd9,  2'd3, 16'd0, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'd9, 15,   9'h001, 4'd9,  2'd3, 16'd0, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd9, 16,   9'h002, 4'd9,  2'd3, 16'd0, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd9, 17,   9'h002, 4'd9,  2'd3, 16'd0, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd9, 128,  9'h100, 4'd9,  2'd3, 16'd0, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 4'd9, 144,  9'h001, 4'd3,  2'd3, 16'd1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 4'd3, 288,  9'h001, 4'd6,  2'd3, 16'd2, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 4'd6, 432,  9'h001, 4'd13, 2'd3, 16'd3, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'd0, 576,  9'h001, 4'd10, 2'd2, 16'd3, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'd0, 577,  9'h001, 4'd10, 2'd2, 16'd3, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 4'd0, 720,  9'h001, 4'd5,  2'd1, 16'd3, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'd0, 864,  9'h001, 4'd11, 2'd0, 16'd3, 2'd3, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 4'd0, 865,  9'h001, 4'd11, 2'd0, 16'd3, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 4'd0, 1065, 9'h001, 4'd11, 2'd0, 16'd3, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 4'd0, 0,    9'h001, 4'd11, 2'd3, 16'd0, 2'd1, 1'b0, 1'b0, 1'b0};

        // reset held for two cycles
        clr = 1'b1;
        tick();
        tick();
        chk_all("reset", 9'h001, 4'd9, 2'd3, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        tick();

        // table: single passes, then misses down to game over, then restart
        for (int i = 0; i < 15; i++) begin
            plrpos = vecs[i].plr;
            if (vecs[i].do_start) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                c = 0;
            end else begin
                run_to(vecs[i].cyc);
            end
            chk_all($sformatf("vec%0d", i), vecs[i].bar, vecs[i].hole, vecs[i].lv,
                    vecs[i].ta, vecs[i].st, vecs[i].bs, vecs[i].ht, vecs[i].go);
        end

        // clr during PLAY
        run_to(50);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_all("midclr", 9'h001, 4'd9, 2'd3, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        // start during PLAY is ignored and the divider phase is kept
        fresh_game();
        run_to(20);
        start = 1'b1;
        tick();
        c++;
        start = 1'b0;
        chk("ign_start.state", 64'(state), 64'(1));
        chk("ign_start.lives", 64'(lives), 64'(3));
        run_to(31);
        chk("ign_start.nostep31", 64'(bar_step), 64'(0));
        run_to(32);
        chk("ign_start.step32", 64'(bar_step), 64'(1));
        chk("ign_start.bar32", 64'(barpos), 64'(9'h004));

        // 50-cycle pause mid-lap shifts later steps by 50
        run_to(40);
        pause = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            c++;
            if (i == 0) chk("pause.state", 64'(state), 64'(2));
            if (bar_step !== 1'b0 || barpos !== 9'h004)
                chk("pause.frozen", 64'({bar_step, barpos}), 64'({1'b0, 9'h004}));
        end
        pause = 1'b0;
        run_to(97);
        chk("pause.nostep97", 64'(bar_step), 64'(0));
        run_to(98);
        chk("pause.step98", 64'(bar_step), 64'(1));
        chk("pause.bar98", 64'(barpos), 64'(9'h008));
        run_to(114);
        chk("pause.step114", 64'({bar_step, barpos}), 64'({1'b1, 9'h010}));

        // pause on the wrap cycle defers the step to the resume cycle
        fresh_game();
        run_to(15);
        pause = 1'b1;
        tick();
        c++;
        pause = 1'b0;
        chk("wrap_pause.state", 64'(state), 64'(2));
        chk("wrap_pause.nostep", 64'({bar_step, barpos}), 64'({1'b0, 9'h001}));
        tick();
        c++;
        chk("wrap_pause.resume", 64'({state, bar_step, barpos}), 64'({2'd1, 1'b1, 9'h002}));

        // speed ramp with the player always under the hole
        fresh_game();
        passes = 0;
        last = 0;
        while (passes < 52 && c < 20000) begin
            plrpos = holepos;
            tick();
            c++;
            if (bar_step) begin
                chk($sformatf("ramp.interval_p%0d", passes), 64'(c - last), 64'(cur_period(passes)));
                chk("ramp.hit", 64'(hit), 64'(0));
                last = c;
                if (barpos == 9'h001) passes++;
            end
        end
        chk("ramp.budget", 64'(passes), 64'(52));
        chk("ramp.timealive", 64'(timealive), 64'(52));

        // randomized run against the reference model
        pause_left = 0;
        for (int i = 0; i < 6000; i++) begin
            r_clr   = (i == 0) || ($urandom_range(0, 999) == 0);
            r_start = ($urandom_range(0, 99) == 0);
            if (pause_left > 0) begin
                pause = 1'b1;
                pause_left--;
            end else begin
                pause = 1'b0;
                if ($urandom_range(0, 149) == 0) pause_left = $urandom_range(1, 30);
            end
            r_plr = ($urandom_range(0, 9) < 7) ? m_hole : 4'($urandom_range(0, 15));
            clr = r_clr;
            start = r_start;
            plrpos = r_plr;
            @(posedge gameclk);
            model_edge(r_clr, r_start, pause, r_plr);
            #1;
            exp_v = 64'({9'(1 << m_row), m_hole, 2'(m_lives), 16'(m_ta), 2'(m_state),
                         m_bs, m_hit, (m_state == 3)});
            chk($sformatf("rand%0d", i),
                64'({barpos, holepos, lives, timealive, state, bar_step, hit, game_over}), exp_v);
        end
        clr = 1'b0;
        start = 1'b0;
        pause = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_seq.md
# game_seq

Round sequencer for the falling-bar game. It owns the game FSM (idle / play / pause / over) and paces bar descent with a speed-ramping tick divider. It picks each new hole column from an LFSR, judges pass or hit when the bar leaves the bottom row, and maintains `lives` and `timealive`. It sits between the button/switch debouncers (start, pause, `plrpos`) and the display path that renders `barpos`, `holepos`, `lives` and `timealive`.

## Interface
Parameters:
- `START_PERIOD`, default 16: `gameclk` cycles per bar step at game start (≥ `MIN_PERIOD`).
- `MIN_PERIOD`, default 4: fastest step period (≥ 2).
- `LIVES_INIT`, default 3: lives at game start (1..3).
- `SEED`, default 4'h9: LFSR seed and reset value of `holepos` (nonzero).

Ports:
- `gameclk`, in, 1: sole clock, rising edge.
- `clr`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: single-cycle pulse that starts or restarts a game.
- `pause`, in, 1: level; freezes play while high.
- `plrpos`, in, 4: player column, 0..15.
- `barpos`, out, 9: one-hot bar row; bit0 is top, bit8 is bottom.
- `holepos`, out, 4: hole column in the current bar, 1..15.
- `lives`, out, 2: remaining lives.
- `timealive`, out, 16: bars passed, saturating.
- `state`, out, 2: IDLE=0, PLAY=1, PAUSE=2, OVER=3.
- `bar_step`, out, 1: one-cycle pulse on each bar move.
- `hit`, out, 1: one-cycle pulse when a life is lost.
- `game_over`, out, 1: high while in OVER.

## Operation
- **Reset** (`clr` sampled high) sets all registers to their initial values, and `clr` overrides every other input:
  - state = IDLE, `barpos` = 9'h001, `holepos` = `SEED`, `lives` = `LIVES_INIT`, `timealive` = 0.
  - period = `START_PERIOD`, divider = 0, pass count = 0.
  - `bar_step` = `hit` = `game_over` = 0.
- **IDLE or OVER + `start`** → PLAY. This reinitialises `barpos`, `lives`, `timealive`, period, divider and pass count. `holepos` keeps its current LFSR value.
- **`start` in PLAY or PAUSE** is ignored.
- **PLAY**:
  - The divider counts 0..period−1.
  - At period−1 the divider returns to 0 and a step occurs.
  - If `barpos` is not bit8, a step shifts `barpos` left by one.
- **Step with `barpos` == bit8** (evaluation). `plrpos` is sampled in this cycle.
  - `barpos` ← bit0.
  - `holepos` ← next LFSR value, computed as {hp[2:0], hp[3]^hp[2]}. This is x⁴+x³+1, period 15, and the value is never 0.
  - Pass (`plrpos` == `holepos`):
    - `timealive` += 1, saturating at 16'hFFFF.
    - Pass count increments.
    - On every 4th pass, period −= 1, but not below `MIN_PERIOD`.
  - Miss:
    - `hit` pulses and `lives` −= 1.
    - If `lives` was 1, `lives` ← 0, state ← OVER, `game_over` ← 1.
- **PLAY + `pause`** → PAUSE. The divider, `barpos` and `holepos` are frozen. `pause` low → PLAY, resuming from the frozen divider value.
- **Simultaneous pause and step:** when `pause` is high in the cycle the divider is at period−1, pause wins. No step occurs, and the step fires on the first PLAY cycle after resume.
- **OVER:** all outputs hold their final values until `start` or `clr`.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `start` is sampled in cycle 0. From cycle 1: `state` = PLAY, divider = 0.
- The first `bar_step` is visible at cycle `START_PERIOD`, together with the updated `barpos`.
- One full lap (9 steps) takes 9 × period cycles. The evaluation step is the 9th step.
- `hit`, `lives`, `timealive`, `holepos` and `game_over` all update in the same cycle as the evaluating `bar_step`.
- A period change takes effect from the divider wrap at which it is applied.
- Pause latency: `state` shows PAUSE one cycle after `pause` is sampled high. Every PAUSE cycle delays all later steps by exactly one cycle.

## Structure
- The shared package `game_pkg` holds:
  - state encoding constants `ST_IDLE`, `ST_PLAY`, `ST_PAUSE`, `ST_OVER`;
  - the LFSR tap definition;
  - row count 9;
  - the `lives` width.
- The sub-module `game_lfsr` is a 4-bit Fibonacci LFSR with load (seed) and advance enable. It is instantiated once. The divider, FSM and scoring stay in `game_seq`.

## Test plan
- **Reset:** `clr` high for 2 cycles → `state` = 0, `barpos` = 9'h001, `holepos` = 9, `lives` = 3, `timealive` = 0, all pulses 0.
- **Single pass:** `start` pulse with `plrpos` = 9 → `bar_step` at cycles 16, 32, …, 144.
  - At cycle 144: `barpos` = 9'h001, `timealive` = 1, `holepos` = 3, `lives` = 3, `hit` = 0.
  - The following evaluations expect holes 6 then 13.
- **Game over:** `plrpos` = 0 held → `hit` pulses at cycles 144, 288 and 432, with `lives` going 2, 1, 0.
  - At cycle 432: `state` = OVER and `game_over` = 1.
  - Outputs stay constant for 200 more cycles.
  - A later `start` → `lives` = 3, `timealive` = 0.
- **Pause:**
  - `pause` high for 50 cycles mid-lap → all later steps are shifted by exactly 50 cycles and `barpos` is unchanged during the pause.
  - `pause` asserted in the divider==15 cycle → no step that cycle; the step fires on the first PLAY cycle after release.
- **Speed ramp:** `plrpos` tracks `holepos` → period is 15 after 4 passes and 14 after 8. It reaches 4 after 48 passes and never goes below 4. No `hit` is seen.
- **Mid-game reset and ignored start:**
  - `clr` during PLAY → reset values on the next cycle.
  - `start` during PLAY → no change in `state`, `lives`, `timealive` or divider phase.
